// File: rtl/multicycle_decoder_pkg.sv
// Shared encodings for the multicycle ARM control decoder.
package multicycle_decoder_pkg;

  // Main FSM state encodings; 10..15 are illegal and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // ALUControl codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // ResultSrc select codes
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcB select codes
  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // Op field codes (Op=11 is undefined)
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Data-processing cmd codes
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  // Commands whose result also updates the carry/overflow flags.
  function automatic logic cmd_is_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
  endfunction

endpackage

// File: rtl/multicycle_decoder_alu_decoder.sv
// Combinational ALU decoder: ALU operation, flag-write enables and CMP write suppression.
module alu_decoder
  import multicycle_decoder_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] op,
  input  logic       alu_op,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write
);

  logic [3:0] cmd;
  logic       funct_i_unused;

  assign cmd            = funct[4:1];
  // The immediate bit only steers the FSM, not the ALU operation.
  assign funct_i_unused = funct[5];

  // NoWrite depends only on the instruction, so it stays valid through ALUWB.
  assign no_write = (op == OP_DP) && (cmd == CMD_CMP);

  // Decode the ALU operation and flag enables when the FSM requests an ALU op.
  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    if (alu_op) begin
      case (cmd)
        CMD_ADD: alu_control = ALU_ADD;
        CMD_SUB: alu_control = ALU_SUB;
        CMD_AND: alu_control = ALU_AND;
        CMD_ORR: alu_control = ALU_ORR;
        CMD_CMP: alu_control = ALU_SUB;
        default: alu_control = ALU_ADD;
      endcase
      case (cmd)
        CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP:
          flag_w = {funct[0], funct[0] & cmd_is_arith(cmd)};
        default:
          flag_w = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_decoder.sv
// Control decoder for the multicycle ARM datapath: main FSM, PC logic and output decode.
//
// state    | meaning
// ---------+-------------------------------------------------
// FETCH    | load IR, PC <= PC+4
// DECODE   | read registers, precompute PC+8
// MEMADR   | compute memory address (base + imm)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to Rd
// MEMWRITE | write RD2 to memory at ALUOut
// EXECUTER | data-processing with register operand
// EXECUTEI | data-processing with immediate operand
// ALUWB    | write ALU result to Rd
// BRANCH   | PC <= PC+8+imm
module multicycle_decoder
  import multicycle_decoder_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [3:0] State,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       NoWrite
);

  state_t state_q;
  state_t state_d;
  logic   alu_op;
  logic   branch;
  logic   irwrite_s;
  logic   nextpc_s;
  logic   regw_s;
  logic   memw_s;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; illegal encodings fall through to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode; strobes are suppressed while Reset is held so that
  // the FETCH state seen during reset cannot load the IR or advance the PC.
  always_comb begin
    irwrite_s = 1'b0;
    nextpc_s  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    regw_s    = 1'b0;
    memw_s    = 1'b0;
    alu_op    = 1'b0;
    branch    = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite_s = 1'b1;
        nextpc_s  = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR:   ALUSrcB = SRCB_EXTIMM;
      S_MEMREAD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        regw_s    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        memw_s = 1'b1;
      end
      S_EXECUTER: alu_op = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB = SRCB_EXTIMM;
        alu_op  = 1'b1;
      end
      S_ALUWB:    regw_s = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = SRCB_EXTIMM;
        ResultSrc = RES_ALURESULT;
        branch    = 1'b1;
      end
      default: ;
    endcase
    if (Reset) begin
      irwrite_s = 1'b0;
      nextpc_s  = 1'b0;
      regw_s    = 1'b0;
      memw_s    = 1'b0;
      alu_op    = 1'b0;
      branch    = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .funct       (Funct),
    .op          (Op),
    .alu_op      (alu_op),
    .alu_control (ALUControl),
    .flag_w      (FlagW),
    .no_write    (NoWrite)
  );

  assign State   = state_q;
  assign IRWrite = irwrite_s;
  assign NextPC  = nextpc_s;
  assign RegW    = regw_s;
  assign MemW    = memw_s;
  assign ImmSrc  = Op;
  assign RegSrc  = {Op == OP_MEM, Op == OP_BR};
  // A write to R15 redirects the PC in the same cycle as the register write.
  assign PCS     = branch | (regw_s & (Rd == 4'hF));

endmodule

// File: tb/tb_multicycle_decoder.sv
// Self-checking bench for multicycle_decoder using an expected-output scoreboard.
module tb_multicycle_decoder;

  logic       Clk;
  logic       Reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] State;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW;
  logic       PCS, RegW, MemW, NoWrite;

  typedef struct packed {
    logic [3:0] state;
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic [1:0] alucontrol;
    logic [1:0] flagw;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       nowrite;
  } outs_t;

  outs_t sb[$];
  int    checks = 0;
  int    errors = 0;

  multicycle_decoder dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .State(State), .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic outs_t sample();
    return {State, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
            ImmSrc, RegSrc, ALUControl, FlagW, PCS, RegW, MemW, NoWrite};
  endfunction

  // Reference outputs taken from the per-state output table and ALU decoder table.
  function automatic outs_t exp_rec(input int st, input logic [1:0] op,
                                    input logic [5:0] funct, input logic [3:0] rd,
                                    input logic rst);
    outs_t r;
    logic [3:0] cmd;
    logic aluop, br, sup;
    r     = '0;
    cmd   = funct[4:1];
    aluop = 1'b0;
    br    = 1'b0;
    r.state   = st[3:0];
    r.immsrc  = op;
    r.regsrc  = {op == 2'b01, op == 2'b10};
    r.nowrite = (op == 2'b00) && (cmd == 4'b1010);
    case (st)
      0: begin r.irwrite = !rst; r.nextpc = !rst; r.alusrca = 1; r.alusrcb = 2'b10; r.resultsrc = 2'b10; end
      1: begin r.alusrca = 1; r.alusrcb = 2'b10; r.resultsrc = 2'b10; end
      2: r.alusrcb = 2'b01;
      3: r.adrsrc = 1;
      4: begin r.resultsrc = 2'b01; r.regw = 1; end
      5: begin r.adrsrc = 1; r.memw = 1; end
      6: aluop = 1;
      7: begin r.alusrcb = 2'b01; aluop = 1; end
      8: r.regw = 1;
      9: begin r.alusrcb = 2'b01; r.resultsrc = 2'b10; br = 1; end
      default: ;
    endcase
    if (aluop) begin
      sup = 1'b1;
      case (cmd)
        4'b0100: r.alucontrol = 2'b00;
        4'b0010: r.alucontrol = 2'b01;
        4'b0000: r.alucontrol = 2'b10;
        4'b1100: r.alucontrol = 2'b11;
        4'b1010: r.alucontrol = 2'b01;
        default: sup = 1'b0;
      endcase
      if (sup)
        r.flagw = {funct[0], funct[0] & (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010)};
    end
    r.pcs = br | (r.regw & (rd == 4'hF));
    return r;
  endfunction

  function automatic int nxt(input int st, input logic [1:0] op, input logic [5:0] funct);
    case (st)
      0: return 1;
      1: begin
        if (op == 2'b01) return 2;
        if (op == 2'b00) return funct[5] ? 7 : 6;
        if (op == 2'b10) return 9;
        return 0;
      end
      2: return funct[0] ? 3 : 5;
      3: return 4;
      6, 7: return 8;
      default: return 0;
    endcase
  endfunction

  // Drive one instruction and queue its expected per-cycle outputs up to the next FETCH.
  task automatic push_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
    int st;
    Op = op; Funct = funct; Rd = rd;
    st = 0;
    do begin
      sb.push_back(exp_rec(st, op, funct, rd, 1'b0));
      st = nxt(st, op, funct);
    end while (st != 0);
  endtask

  task automatic test_reset();
    outs_t obs, exp;
    Reset = 1'b1; Op = 2'b00; Funct = 6'b000000; Rd = 4'h0;
    #12;
    obs = sample(); exp = exp_rec(0, Op, Funct, Rd, 1'b1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_hold: got %h want %h", obs, exp); end
    @(negedge Clk); Reset = 1'b0; #1;
    obs = sample(); exp = exp_rec(0, Op, Funct, Rd, 1'b0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_release: got %h want %h", obs, exp); end
  endtask

  task automatic test_dp();
    outs_t obs, exp;
    push_instr(2'b00, 6'b101001, 4'h1);   // ADDS R1, imm
    push_instr(2'b00, 6'b001001, 4'h2);   // ADDS reg
    push_instr(2'b00, 6'b010101, 4'h0);   // CMP
    push_instr(2'b00, 6'b011000, 4'hF);   // ORR R15
    push_instr(2'b00, 6'b000001, 4'h3);   // ANDS
    push_instr(2'b00, 6'b111111, 4'h4);   // unsupported cmd
    // Inputs of each instruction must be applied at its own FETCH, so replay them.
    begin
      logic [1:0] ops[6]   = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      logic [5:0] fns[6]   = '{6'b101001, 6'b001001, 6'b010101, 6'b011000, 6'b000001, 6'b111111};
      logic [3:0] rds[6]   = '{4'h1, 4'h2, 4'h0, 4'hF, 4'h3, 4'h4};
      int lens[6]          = '{4, 4, 4, 4, 4, 4};
      for (int i = 0; i < 6; i++) begin
        Op = ops[i]; Funct = fns[i]; Rd = rds[i];
        for (int c = 0; c < lens[i]; c++) begin
          #1;
          exp = sb.pop_front(); obs = sample();
          checks++;
          if (obs !== exp) begin errors++; $display("FAIL dp%0d cyc%0d: got %h want %h", i, c, obs, exp); end
          @(negedge Clk);
        end
      end
    end
    #1; checks++;
    if (State !== 4'd0) begin errors++; $display("FAIL dp_end_state: got %0d want 0", State); end
  endtask

  task automatic test_mem();
    outs_t obs, exp;
    int c;
    push_instr(2'b01, 6'b011001, 4'hF);   // LDR R15: 5 cycles
    c = 0;
    while (sb.size() != 0) begin
      #1; exp = sb.pop_front(); obs = sample();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL ldr cyc%0d: got %h want %h", c, obs, exp); end
      c++; @(negedge Clk);
    end
    push_instr(2'b01, 6'b011000, 4'h3);   // STR: 4 cycles
    c = 0;
    while (sb.size() != 0) begin
      #1; exp = sb.pop_front(); obs = sample();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL str cyc%0d: got %h want %h", c, obs, exp); end
      c++; @(negedge Clk);
    end
    #1; checks++;
    if (State !== 4'd0) begin errors++; $display("FAIL mem_end_state: got %0d want 0", State); end
  endtask

  task automatic test_branch_undef();
    outs_t obs, exp;
    int c;
    push_instr(2'b10, 6'b100000, 4'h0);   // B: 3 cycles
    c = 0;
    while (sb.size() != 0) begin
      #1; exp = sb.pop_front(); obs = sample();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL branch cyc%0d: got %h want %h", c, obs, exp); end
      c++; @(negedge Clk);
    end
    push_instr(2'b11, 6'b111111, 4'hF);   // undefined: 2 cycles, no writes
    c = 0;
    while (sb.size() != 0) begin
      #1; exp = sb.pop_front(); obs = sample();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL undef cyc%0d: got %h want %h", c, obs, exp); end
      c++; @(negedge Clk);
    end
    #1; checks++;
    if (State !== 4'd0) begin errors++; $display("FAIL undef_end_state: got %0d want 0", State); end
  endtask

  task automatic test_reset_mid();
    outs_t obs, exp;
    int c;
    Op = 2'b00; Funct = 6'b001001; Rd = 4'h1;
    @(posedge Clk); @(posedge Clk); #2;
    checks++;
    if (State !== 4'd6) begin errors++; $display("FAIL mid_pre_state: got %0d want 6", State); end
    Reset = 1'b1; #1;
    obs = sample(); exp = exp_rec(0, Op, Funct, Rd, 1'b1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mid_async_reset: got %h want %h", obs, exp); end
    @(posedge Clk); #1;
    obs = sample();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL mid_reset_held: got %h want %h", obs, exp); end
    @(negedge Clk);
    push_instr(2'b00, 6'b101001, 4'h1);   // states 0,1,7,8
    Reset = 1'b0;
    c = 0;
    while (sb.size() != 0) begin
      #1; exp = sb.pop_front(); obs = sample();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mid_after cyc%0d: got %h want %h", c, obs, exp); end
      c++; @(negedge Clk);
    end
    #1; checks++;
    if (State !== 4'd0) begin errors++; $display("FAIL mid_end_state: got %0d want 0", State); end
  endtask

  task automatic test_back_to_back();
    outs_t obs, exp;
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] rd;
    int c;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      fn = 6'($urandom_range(0, 63));
      rd = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      push_instr(op, fn, rd);
      c = 0;
      while (sb.size() != 0) begin
        #1; exp = sb.pop_front(); obs = sample();
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL b2b%0d op%b fn%b cyc%0d: got %h want %h", i, op, fn, c, obs, exp);
        end
        c++; @(negedge Clk);
      end
    end
    #1; checks++;
    if (State !== 4'd0) begin errors++; $display("FAIL b2b_end_state: got %0d want 0", State); end
  endtask

  initial begin
    test_reset();
    test_dp();
    test_mem();
    test_branch_undef();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
